// File: rtl/game_pkg.sv
// Shared game constants, slot owner encoding and the shot scheduler state type.
// The player spawn height is exported here so the renderer draws the gun muzzle at the same row.
package game_pkg;

  localparam int SCR_WIDTH   = 640;
  localparam int SCR_HEIGHT  = 480;
  localparam int SHIP_HGT    = 30;
  localparam int VERT_OFFSET = 10;
  localparam int SHOT_RADIUS = 4;

  localparam logic OWNER_PLAYER = 1'b0;
  localparam logic OWNER_ALIEN  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_ALLOC = 2'd2
  } sched_state_t;

  function automatic logic [9:0] spawn_y(input int height, input int v_off,
                                         input int ship_h, input int radius);
    return 10'(height - v_off - ship_h - radius);
  endfunction

  localparam logic [9:0] PLAYER_SPAWN_Y =
    spawn_y(SCR_HEIGHT, VERT_OFFSET, SHIP_HGT, SHOT_RADIUS);

endpackage

// File: rtl/free_slot_finder.sv
// Lowest-index priority encoder over a free-slot mask.
// o_found is low when no slot is free; o_idx is then 0 and must be ignored.
module free_slot_finder #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_free,
  output logic [2:0]   o_idx,
  output logic         o_found
);

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    // Scan downward so the lowest free index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_free[i]) begin
        o_idx   = 3'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shot_scheduler.sv
// Per-frame projectile scheduler: steps every live shot, then grants player/alien fire into free slots.
//   state    | meaning
//   ST_IDLE  | waiting for the frame tick
//   ST_MOVE  | stepping slot[r_idx], one slot per cycle
//   ST_ALLOC | grant pending requests, clear pending flags, age cooldown
module shot_scheduler
  import game_pkg::*;
#(
  parameter int NUM_SLOTS     = 4,
  parameter int COOLDOWN      = 30,
  parameter int STEP_MOTION   = 1,
  parameter int SCREEN_WIDTH  = SCR_WIDTH,
  parameter int SCREEN_HEIGHT = SCR_HEIGHT,
  parameter int SHIP_HEIGHT   = SHIP_HGT,
  parameter int V_OFFSET      = VERT_OFFSET,
  parameter int RADIUS        = SHOT_RADIUS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    fire,
  input  logic                    alienFire,
  input  logic [9:0]              gunPosition,
  input  logic [9:0]              alienX,
  input  logic [9:0]              alienY,
  input  logic [NUM_SLOTS-1:0]    killSlot,
  output logic [NUM_SLOTS-1:0]    slotAlive,
  output logic [NUM_SLOTS-1:0]    slotOwner,
  output logic [10*NUM_SLOTS-1:0] xShot,
  output logic [10*NUM_SLOTS-1:0] yShot,
  output logic                    fireAccepted,
  output logic                    alienFireAccepted,
  output logic                    busy
);

  localparam int         CW      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [9:0] SPAWN_Y = spawn_y(SCREEN_HEIGHT, V_OFFSET, SHIP_HEIGHT, RADIUS);
  localparam logic [9:0] PARK_X  = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0] PARK_Y  = 10'(SCREEN_HEIGHT - 1);

  sched_state_t           r_state, w_state_next;
  logic [2:0]             r_idx;
  logic [NUM_SLOTS-1:0]   r_alive, r_owner;
  logic [9:0]             r_x [NUM_SLOTS];
  logic [9:0]             r_y [NUM_SLOTS];
  logic                   r_pend_p, r_pend_a;
  logic [CW-1:0]          r_cool;
  logic                   r_fire_acc, r_alien_acc;

  logic [NUM_SLOTS-1:0]   w_free, w_p_mask;
  logic [2:0]             w_p_idx, w_a_idx;
  logic                   w_p_found, w_a_found, w_p_grant, w_a_grant, w_player_live;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (enable) w_state_next = ST_MOVE;
      ST_MOVE:  if (r_idx == 3'(NUM_SLOTS - 1)) w_state_next = ST_ALLOC;
      ST_ALLOC: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // A slot killed this cycle is not offered for allocation; it frees up next cycle.
  assign w_free        = ~r_alive & ~killSlot;
  assign w_player_live = |(r_alive & ~r_owner);

  free_slot_finder #(.N(NUM_SLOTS)) u_find_player (
    .i_free (w_free),
    .o_idx  (w_p_idx),
    .o_found(w_p_found)
  );

  assign w_p_grant = (r_state == ST_ALLOC) && r_pend_p && (r_cool == '0) &&
                     !w_player_live && w_p_found;
  assign w_p_mask  = w_p_grant ? (NUM_SLOTS'(1) << w_p_idx) : '0;

  free_slot_finder #(.N(NUM_SLOTS)) u_find_alien (
    .i_free (w_free & ~w_p_mask),
    .o_idx  (w_a_idx),
    .o_found(w_a_found)
  );

  assign w_a_grant = (r_state == ST_ALLOC) && r_pend_a && w_a_found;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_alive     <= '0;
      r_owner     <= '0;
      r_pend_p    <= 1'b0;
      r_pend_a    <= 1'b0;
      r_cool      <= '0;
      r_fire_acc  <= 1'b0;
      r_alien_acc <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_x[i] <= PARK_X;
        r_y[i] <= PARK_Y;
      end
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && enable) r_idx <= '0;
      else if (r_state == ST_MOVE)      r_idx <= r_idx + 3'd1;

      // Requests seen during ALLOC survive the clear and wait for the next frame.
      r_pend_p    <= (r_state == ST_ALLOC) ? fire      : (r_pend_p | fire);
      r_pend_a    <= (r_state == ST_ALLOC) ? alienFire : (r_pend_a | alienFire);
      r_fire_acc  <= w_p_grant;
      r_alien_acc <= w_a_grant;

      if (w_p_grant)                              r_cool <= CW'(COOLDOWN);
      else if (r_state == ST_ALLOC && r_cool != '0) r_cool <= r_cool - CW'(1);

      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (killSlot[i]) begin
          r_alive[i] <= 1'b0;
          r_owner[i] <= OWNER_PLAYER;
          r_x[i]     <= PARK_X;
          r_y[i]     <= PARK_Y;
        end else if (w_p_grant && w_p_idx == 3'(i)) begin
          r_alive[i] <= 1'b1;
          r_owner[i] <= OWNER_PLAYER;
          r_x[i]     <= gunPosition;
          r_y[i]     <= SPAWN_Y;
        end else if (w_a_grant && w_a_idx == 3'(i)) begin
          r_alive[i] <= 1'b1;
          r_owner[i] <= OWNER_ALIEN;
          r_x[i]     <= alienX;
          r_y[i]     <= 10'(alienY + 10'(RADIUS));
        end else if (r_state == ST_MOVE && r_idx == 3'(i) && r_alive[i]) begin
          if (r_owner[i] == OWNER_PLAYER && r_y[i] >= 10'(STEP_MOTION)) begin
            r_y[i] <= r_y[i] - 10'(STEP_MOTION);
          end else if (r_owner[i] == OWNER_ALIEN &&
                       ({1'b0, r_y[i]} + 11'(STEP_MOTION)) <= 11'(SCREEN_HEIGHT - 1)) begin
            r_y[i] <= r_y[i] + 10'(STEP_MOTION);
          end else begin
            r_alive[i] <= 1'b0;
            r_owner[i] <= OWNER_PLAYER;
            r_x[i]     <= PARK_X;
            r_y[i]     <= PARK_Y;
          end
        end
      end
    end
  end

  always_comb begin
    xShot = '0;
    yShot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      xShot[10*i +: 10] = r_x[i];
      yShot[10*i +: 10] = r_y[i];
    end
  end

  assign slotAlive         = r_alive;
  assign slotOwner         = r_owner;
  assign fireAccepted      = r_fire_acc;
  assign alienFireAccepted = r_alien_acc;
  assign busy              = (r_state != ST_IDLE);

endmodule

// File: doc/shot_scheduler.md
# shot_scheduler

Frame-rate controller for the game's projectile datapath. It owns a small pool of shot slots shared between the player gun and the alien formation. It arbitrates fire requests into free slots, enforces a player cooldown, and steps every live shot once per frame. It retires shots on collision or when they leave the screen. It sits between the input/alien-AI logic and the renderer/collision logic, which consume the flattened slot positions.

## Interface
Parameters:
- NUM_SLOTS, 4, shot slots in the pool (2..8)
- COOLDOWN, 30, frames between accepted player shots
- STEP_MOTION, 1, pixels moved per frame
- SCREEN_WIDTH, 640; SCREEN_HEIGHT, 480
- SHIP_HEIGHT, 30; V_OFFSET, 10; RADIUS, 4

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- enable  in  1  one-cycle frame tick
- fire  in  1  player fire request (any cycle)
- alienFire  in  1  alien fire request (any cycle)
- gunPosition  in  10  player gun x
- alienX, alienY  in  10 each  shooting alien's position
- killSlot  in  NUM_SLOTS  per-slot collision kill, one bit per slot
- slotAlive  out  NUM_SLOTS  live mask
- slotOwner  out  NUM_SLOTS  1 = alien shot (moves down), 0 = player shot (moves up)
- xShot, yShot  out  10*NUM_SLOTS each  slot i occupies bits [10i+9:10i]
- fireAccepted, alienFireAccepted  out  1 each  one-cycle grant pulses
- busy  out  1  high while not IDLE

## Operation
- FSM states: IDLE, MOVE, ALLOC. A 3-bit slot index counter drives MOVE.
- IDLE: enable moves the FSM to MOVE with index = 0.
- MOVE: processes slot[index] in one cycle; after index NUM_SLOTS-1 the FSM goes to ALLOC.
  - Player slot: if y >= STEP_MOTION, y -= STEP_MOTION; else the slot is freed.
  - Alien slot: if y + STEP_MOTION <= SCREEN_HEIGHT-1, y += STEP_MOTION; else the slot is freed.
- ALLOC: single cycle, then IDLE.
  - Player grant: pendingPlayer and cooldown == 0 and no live player shot and a free slot exists. The slot is the lowest free index. It loads x = gunPosition, y = SCREEN_HEIGHT-V_OFFSET-SHIP_HEIGHT-RADIUS (436), owner 0. cooldown loads COOLDOWN and fireAccepted pulses.
  - Alien grant: pendingAlien and a free slot remains after the player grant. Lowest free index. It loads x = alienX, y = alienY+RADIUS, owner 1, and alienFireAccepted pulses.
  - Both pending flags clear in ALLOC, whether granted or dropped.
  - If cooldown was nonzero and not reloaded this ALLOC, it decrements by 1.
- Pending flags set on any cycle with fire/alienFire high, including during MOVE/ALLOC. A request arriving in the ALLOC cycle itself is held for the next frame.
- Freed slot: alive = 0, parked at x = SCREEN_WIDTH-1, y = SCREEN_HEIGHT-1, owner 0.
- killSlot[i] frees slot i in any state. It takes priority over motion and allocation of that slot in the same cycle. A slot freed by kill becomes allocatable from the next cycle.
- Arithmetic is unsigned 10-bit. The comparisons above guarantee no wrap.

## Timing
- Reset values:
  - state IDLE, all slots free and parked, pending flags 0, cooldown 0.
  - All pulses 0, busy 0.
- Frame sequence: enable at cycle t; MOVE covers t+1..t+NUM_SLOTS; ALLOC at t+NUM_SLOTS+1; IDLE at t+NUM_SLOTS+2.
- Grant pulses are registered and high only in the cycle after ALLOC.
- enable while busy is ignored, with no queuing.
- Shots allocated in a frame do not move until the next frame.
- Reset mid-frame returns everything to reset values on the next edge.

## Structure
- Shared package `game_pkg`:
  - screen constants (width, height, ship height, V_OFFSET, RADIUS)
  - owner encoding
  - FSM state enum
  - the player spawn-y constant (shared with the renderer)
- Sub-module `free_slot_finder`: combinational lowest-free-index priority encoder with a found flag. It is instantiated twice: once on the raw free mask, once on the mask with the player pick removed.

## Test plan
- Reset, then 3 enable ticks with no requests: all slotAlive = 0, every slot parked at (639,479), no grant pulses.
- gunPosition = 200, fire pulse, enable: fireAccepted one cycle after ALLOC. Slot 0 at (200,436). Next frame slot 0 is at (200,435).
- fire and alienFire in the same frame, alienX = 100, alienY = 50: slot 0 is the player shot and slot 1 is alien at (100,54). Both pulses fire together.
- A second fire in the next frame is dropped: no fireAccepted. After the player shot dies, fire is still refused until 30 frames after the first grant.
- All 4 slots alive and alienFire: dropped. Assert killSlot = 4'b0100 in the ALLOC cycle: the request is still dropped. Next frame a new alienFire is granted into slot 2.
- Player shot at y = 0 on enable: freed in its MOVE cycle. Alien shot at y = 479: freed. Reset asserted during MOVE: all outputs at reset values.
